// File: rtl/accum_pkg.sv
// Shared types and helpers for the accumulator bank.
//   accum_state_t : sweep controller states
//   addr_w()      : entry-index width for a given depth
//   ACC_MAX/MIN   : signed limits of a default-width (32-bit) accumulator entry
// Optional feature macro used by this slice: ACCUM_SAT_EN (saturating accumulate).
package accum_pkg;

  typedef enum logic {
    ACC_IDLE  = 1'b0,
    ACC_CLEAR = 1'b1
  } accum_state_t;

  localparam int ACC_WIDTH_DEF = 32;
  localparam logic [ACC_WIDTH_DEF-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH_DEF-1){1'b1}}};
  localparam logic [ACC_WIDTH_DEF-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH_DEF-1){1'b0}}};

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/accum_sat_add.sv
// Per-column combinational update for one accumulator entry.
// Ports:
//   acc_i      : current entry value (signed, ACC_WIDTH)
//   data_i     : incoming partial product (signed, DATA_WIDTH)
//   acc_mode_i : 1 = entry + data, 0 = overwrite with sign-extended data
//   result_o   : new entry value
//   ovf_o      : accumulate overflowed and was clamped
// Macro ACCUM_SAT_EN: defined -> clamp on overflow; undefined -> wrap, ovf_o = 0.
module accum_sat_add
  import accum_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic [ACC_WIDTH-1:0]  acc_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  acc_mode_i,
  output logic [ACC_WIDTH-1:0]  result_o,
  output logic                  ovf_o
);

  logic [ACC_WIDTH-1:0] data_ext;
  assign data_ext = ACC_WIDTH'($signed(data_i));

`ifdef ACCUM_SAT_EN
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH:0] sum_wide;
  assign sum_wide = {acc_i[ACC_WIDTH-1], acc_i} + {data_ext[ACC_WIDTH-1], data_ext};

  // Top two bits of the widened sum disagree only when the true result left the range.
  assign ovf_o = acc_mode_i & (sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1]);

  always_comb begin
    result_o = data_ext;
    if (acc_mode_i) begin
      if (ovf_o) result_o = sum_wide[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
      else       result_o = sum_wide[ACC_WIDTH-1:0];
    end
  end
`else
  logic [ACC_WIDTH-1:0] sum_wrap;
  assign sum_wrap = acc_i + data_ext;
  assign result_o = acc_mode_i ? sum_wrap : data_ext;
  assign ovf_o    = 1'b0;
`endif

endmodule

// File: rtl/accum_bank.sv
// Multi-column partial-sum accumulator bank (systolic-array output path).
// Ports:
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   clear / busy       : start a zeroing sweep / sweep in progress
//   wr_en, wr_acc      : write request, 1 = accumulate, 0 = overwrite
//   wr_mask, wr_addr   : per-column enable, shared entry index
//   wr_data            : column c at [c*DATA_WIDTH +: DATA_WIDTH]
//   rd_en, rd_addr     : read request and entry index
//   rd_valid, rd_data  : registered read result, column c at [c*ACC_WIDTH +: ACC_WIDTH]
//   sat_flag           : sticky per-column saturation flag
// Macro ACCUM_SAT_EN enables saturating accumulate (see accum_sat_add).
//
// state     | meaning
// ACC_IDLE  | accepting reads and writes
// ACC_CLEAR | zeroing entry ptr_q of every column each cycle, busy high
module accum_bank
  import accum_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_COLS   = 16,
  parameter int DEPTH      = 1024,
  localparam int AW        = addr_w(DEPTH)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           clear,
  output logic                           busy,
  input  logic                           wr_en,
  input  logic                           wr_acc,
  input  logic [NUM_COLS-1:0]            wr_mask,
  input  logic [AW-1:0]                  wr_addr,
  input  logic [NUM_COLS*DATA_WIDTH-1:0] wr_data,
  input  logic                           rd_en,
  input  logic [AW-1:0]                  rd_addr,
  output logic                           rd_valid,
  output logic [NUM_COLS*ACC_WIDTH-1:0]  rd_data,
  output logic [NUM_COLS-1:0]            sat_flag
);

  accum_state_t  state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          sweep_we;
  logic          rd_valid_q;
  logic          wr_in_range, rd_in_range;
  logic          wr_ok, rd_ok;

  // Out-of-range addresses exist only when DEPTH is not a power of two.
  if (DEPTH == (1 << AW)) begin : g_full_range
    assign wr_in_range = 1'b1;
    assign rd_in_range = 1'b1;
  end else begin : g_part_range
    assign wr_in_range = (wr_addr < AW'(DEPTH));
    assign rd_in_range = (rd_addr < AW'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ACC_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sweep_we = 1'b0;
    if (clear) begin
      state_d = ACC_CLEAR;
      ptr_d   = '0;
    end else begin
      case (state_q)
        ACC_CLEAR: begin
          sweep_we = 1'b1;
          if (ptr_q == AW'(DEPTH - 1)) begin
            state_d = ACC_IDLE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state_q == ACC_CLEAR);
  assign wr_ok = (state_q == ACC_IDLE) && !clear && wr_en && wr_in_range;
  assign rd_ok = (state_q == ACC_IDLE) && !clear && rd_en;

  always_ff @(posedge clock) begin
    if (reset) rd_valid_q <= 1'b0;
    else       rd_valid_q <= rd_ok;
  end
  assign rd_valid = rd_valid_q;

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    logic [ACC_WIDTH-1:0] mem_q [DEPTH];
    logic [ACC_WIDTH-1:0] rd_q;
    logic [ACC_WIDTH-1:0] old_val, new_val;
    logic                 ovf;
    logic                 sat_q;

    assign old_val = wr_in_range ? mem_q[wr_addr] : '0;

    accum_sat_add #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_add (
      .acc_i      (old_val),
      .data_i     (wr_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .acc_mode_i (wr_acc),
      .result_o   (new_val),
      .ovf_o      (ovf)
    );

    // Storage is deliberately not reset; the sweep zeroes it over DEPTH cycles.
    always_ff @(posedge clock) begin
      if (sweep_we)                mem_q[ptr_q]   <= '0;
      else if (wr_ok && wr_mask[c]) mem_q[wr_addr] <= new_val;
    end

    always_ff @(posedge clock) begin
      if (reset)      rd_q <= '0;
      else if (rd_ok) rd_q <= rd_in_range ? mem_q[rd_addr] : '0;
    end

    always_ff @(posedge clock) begin
      if (reset || clear)                  sat_q <= 1'b0;
      else if (wr_ok && wr_mask[c] && ovf) sat_q <= 1'b1;
    end

    assign rd_data[c*ACC_WIDTH +: ACC_WIDTH] = rd_q;
    assign sat_flag[c]                       = sat_q;
  end

endmodule

// File: tb/tb_accum_bank.sv
module tb_accum_bank;

  localparam int DW  = 16;
  localparam int ACW = 16;
  localparam int NC  = 16;
  localparam int DEP = 16;
  localparam int AWD = 4;
`ifdef ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                clock = 1'b0;
  logic                reset, clear, busy, wr_en, wr_acc, rd_en, rd_valid;
  logic [NC-1:0]       wr_mask, sat_flag;
  logic [AWD-1:0]      wr_addr, rd_addr;
  logic [NC*DW-1:0]    wr_data;
  logic [NC*ACW-1:0]   rd_data;

  always #5 clock = ~clock;

  accum_bank #(.DATA_WIDTH(DW), .ACC_WIDTH(ACW), .NUM_COLS(NC), .DEPTH(DEP)) dut (
    .clock(clock), .reset(reset), .clear(clear), .busy(busy),
    .wr_en(wr_en), .wr_acc(wr_acc), .wr_mask(wr_mask), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .sat_flag(sat_flag)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: plain integer arrays, one sweep counter.
  int          m_mem [DEP][NC];
  int          m_rd  [NC];
  bit          m_valid;
  int          m_left;
  bit [NC-1:0] m_sat;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic int fit(input int s, output bit ov);
    logic signed [15:0] t;
    ov = 1'b0;
    if (SAT) begin
      if (s > 32767)  begin ov = 1'b1; return 32767;  end
      if (s < -32768) begin ov = 1'b1; return -32768; end
      return s;
    end
    t = s[15:0];
    return int'(t);
  endfunction

  task automatic model_edge();
    bit ov;
    int d;
    if (reset || clear) begin
      m_left = DEP; m_valid = 1'b0; m_sat = '0;
      if (reset) foreach (m_rd[c]) m_rd[c] = 0;
      foreach (m_mem[a, c]) m_mem[a][c] = 0;
    end else if (m_left > 0) begin
      m_left--; m_valid = 1'b0;
    end else begin
      m_valid = rd_en;
      if (rd_en) foreach (m_rd[c]) m_rd[c] = m_mem[rd_addr][c];
      if (wr_en) for (int c = 0; c < NC; c++) if (wr_mask[c]) begin
        d = int'($signed(wr_data[c*DW +: DW]));
        if (wr_acc) begin
          m_mem[wr_addr][c] = fit(m_mem[wr_addr][c] + d, ov);
          if (ov) m_sat[c] = 1'b1;
        end else m_mem[wr_addr][c] = d;
      end
    end
  endtask

  task automatic cyc(input string nm);
    logic [NC*ACW-1:0] exp_rd;
    model_edge();
    @(posedge clock);
    #1;
    foreach (m_rd[c]) exp_rd[c*ACW +: ACW] = 16'(m_rd[c]);
    chk({nm, ".busy"},     256'(busy),     256'(m_left > 0));
    chk({nm, ".rd_valid"}, 256'(rd_valid), 256'(m_valid));
    chk({nm, ".rd_data"},  256'(rd_data),  256'(exp_rd));
    chk({nm, ".sat_flag"}, 256'(sat_flag), 256'(m_sat));
  endtask

  task automatic idle_in();
    reset = 0; clear = 0; wr_en = 0; wr_acc = 0; wr_mask = '0;
    wr_addr = '0; wr_data = '0; rd_en = 0; rd_addr = '0;
  endtask

  typedef struct {
    bit          we;
    bit          acc;
    logic [15:0] mask;
    logic [3:0]  wa;
    logic [15:0] d0;
    logic [15:0] dx;
    bit          re;
    logic [3:0]  ra;
    bit          ev;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [15:0] esat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit we, bit acc, logic [15:0] mask, logic [3:0] wa,
                              logic [15:0] d0, logic [15:0] dx, bit re, logic [3:0] ra,
                              bit ev, logic [15:0] e0, logic [15:0] e1, logic [15:0] esat);
    vec_t v;
    v.we = we; v.acc = acc; v.mask = mask; v.wa = wa; v.d0 = d0; v.dx = dx;
    v.re = re; v.ra = ra; v.ev = ev; v.e0 = e0; v.e1 = e1; v.esat = esat;
    return v;
  endfunction

  initial begin
    int bc;
    logic [15:0] sat_col1, wrap_col1;
    sat_col1  = SAT ? 16'h0002 : 16'h0000;
    wrap_col1 = SAT ? 16'h7FFF : 16'h8000;

    //              we acc mask     wa  d0       dx       re ra ev e0       e1         esat
    tbl.push_back(mk(1, 1, 16'h0001, 3, 16'd5,   16'd0,   0, 0, 0, 16'h0000, 16'h0000, 16'h0));
    tbl.push_back(mk(1, 1, 16'h0001, 3, 16'hFFFE, 16'd0,  0, 0, 0, 16'h0000, 16'h0000, 16'h0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'd0,   16'd0,   1, 3, 1, 16'h0003, 16'h0000, 16'h0));
    tbl.push_back(mk(1, 0, 16'h0001, 7, 16'd7,   16'd7,   0, 0, 0, 16'h0003, 16'h0000, 16'h0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'd0,   16'd0,   1, 7, 1, 16'h0007, 16'h0000, 16'h0));
    tbl.push_back(mk(1, 0, 16'h0001, 7, 16'hFFFF, 16'd0,  0, 0, 0, 16'h0007, 16'h0000, 16'h0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'd0,   16'd0,   1, 7, 1, 16'hFFFF, 16'h0000, 16'h0));
    tbl.push_back(mk(1, 0, 16'hFFFF, 5, 16'd10,  16'd10,  0, 0, 0, 16'hFFFF, 16'h0000, 16'h0));
    tbl.push_back(mk(1, 1, 16'hFFFF, 5, 16'd4,   16'd4,   1, 5, 1, 16'h000A, 16'h000A, 16'h0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'd0,   16'd0,   1, 5, 1, 16'h000E, 16'h000E, 16'h0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'd0,   16'd0,   0, 0, 0, 16'h000E, 16'h000E, 16'h0));
    tbl.push_back(mk(1, 0, 16'h0002, 9, 16'd0,   16'h7FFF, 0, 0, 0, 16'h000E, 16'h000E, 16'h0));
    tbl.push_back(mk(1, 1, 16'h0002, 9, 16'd0,   16'h0001, 0, 0, 0, 16'h000E, 16'h000E, sat_col1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'd0,   16'd0,   1, 9, 1, 16'h0000, wrap_col1, sat_col1));
    tbl.push_back(mk(1, 1, 16'hFFFF, 15, 16'hFFFD, 16'hFFFD, 0, 0, 0, 16'h0000, wrap_col1, sat_col1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'd0,   16'd0,   1, 15, 1, 16'hFFFD, 16'hFFFD, sat_col1));

    idle_in();
    reset = 1;
    cyc("reset");
    reset = 0;

    bc = 0;
    while (busy && bc < 40) begin cyc("sweep"); bc++; end
    chk("reset_sweep_len", 256'(bc), 256'(DEP));

    for (int a = 0; a < DEP; a++) begin
      rd_en = 1; rd_addr = AWD'(a);
      cyc("rd_zero");
    end
    idle_in();
    cyc("rd_idle");

    foreach (tbl[i]) begin
      wr_en = tbl[i].we; wr_acc = tbl[i].acc; wr_mask = tbl[i].mask; wr_addr = tbl[i].wa;
      for (int c = 0; c < NC; c++) wr_data[c*DW +: DW] = (c == 0) ? tbl[i].d0 : tbl[i].dx;
      rd_en = tbl[i].re; rd_addr = tbl[i].ra;
      cyc("tbl");
      chk($sformatf("tbl%0d.valid", i), 256'(rd_valid),          256'(tbl[i].ev));
      chk($sformatf("tbl%0d.col0", i),  256'(rd_data[15:0]),     256'(tbl[i].e0));
      chk($sformatf("tbl%0d.col1", i),  256'(rd_data[31:16]),    256'(tbl[i].e1));
      chk($sformatf("tbl%0d.sat", i),   256'(sat_flag),          256'(tbl[i].esat));
    end
    idle_in();

    // Clear, restart the sweep at ptr 8, hammer writes while busy.
    clear = 1; cyc("clr1"); clear = 0;
    for (int k = 0; k < 8; k++) begin
      wr_en = 1; wr_acc = 0; wr_mask = '1; wr_addr = AWD'(k); wr_data = {NC{16'h1234}};
      cyc("clr_busy_wr");
    end
    wr_en = 0;
    clear = 1; cyc("clr2"); clear = 0;
    bc = 0;
    while (busy && bc < 40) begin
      wr_en = 1; wr_acc = 1; wr_mask = '1; wr_addr = AWD'(bc % DEP); wr_data = {NC{16'h0055}};
      rd_en = 1; rd_addr = AWD'(bc % DEP);
      cyc("restart_sweep");
      chk("busy_rd_dropped", 256'(rd_valid), 256'(0));
      bc++;
    end
    chk("restart_sweep_len", 256'(bc), 256'(DEP));
    idle_in();
    for (int a = 0; a < DEP; a++) begin
      rd_en = 1; rd_addr = AWD'(a);
      cyc("rd_after_clear");
      chk("rd_after_clear.zero", 256'(rd_data), 256'(0));
    end
    idle_in();

    // Randomized traffic against the model, biased toward overflow.
    for (int n = 0; n < 400; n++) begin
      clear   = ($urandom_range(0, 79) == 0);
      wr_en   = $urandom_range(0, 1);
      wr_acc  = ($urandom_range(0, 3) != 0);
      wr_mask = NC'($urandom);
      wr_addr = AWD'($urandom);
      for (int c = 0; c < NC; c++) begin
        case ($urandom_range(0, 3))
          0:       wr_data[c*DW +: DW] = 16'h7FFF;
          1:       wr_data[c*DW +: DW] = 16'h8000;
          default: wr_data[c*DW +: DW] = 16'($urandom);
        endcase
      end
      rd_en   = $urandom_range(0, 1);
      rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : AWD'($urandom);
      cyc("rand");
    end
    idle_in();

    reset = 1; cyc("reset2"); reset = 0;
    chk("reset2.busy", 256'(busy), 256'(1));
    chk("reset2.rd_data", 256'(rd_data), 256'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
